// File: rtl/snake_move.sv
// Snake movement engine: step timing, direction filtering, body shift,
// growth and wall/self collision detection for a GRID_W x GRID_H playfield.
module snake_move #(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int MAX_LEN = 16,
    parameter int P_SLOW  = 50_000_000,
    parameter int P_MED   = 25_000_000,
    parameter int P_FAST  = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_state,
    input  logic [3:0] BTN,
    input  logic [2:0] SW,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    input  logic [3:0] qry_idx,
    output logic [4:0] seg_x,
    output logic [4:0] seg_y,
    output logic       seg_valid,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    output logic       step,
    output logic       ate_food,
    output logic       hit_wall,
    output logic       hit_self
);

    typedef enum logic [1:0] {
        GS_START   = 2'b00,
        GS_PAUSE   = 2'b01,
        GS_OVER    = 2'b10,
        GS_PLAYING = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [4:0]  X_MAX    = 5'(GRID_W - 1);
    localparam logic [4:0]  Y_MAX    = 5'(GRID_H - 1);
    localparam logic [4:0]  LEN_MAX  = 5'(MAX_LEN);
    localparam logic [31:0] PER_SLOW = 32'(P_SLOW);
    localparam logic [31:0] PER_MED  = 32'(P_MED);
    localparam logic [31:0] PER_FAST = 32'(P_FAST);

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    function automatic logic [4:0] init_x(input int unsigned i);
        return (i < 3) ? 5'(16 - i) : '0;
    endfunction

    function automatic logic [4:0] init_y(input int unsigned i);
        return (i < 3) ? 5'd12 : '0;
    endfunction

    logic [4:0]  seg_x_q [MAX_LEN];
    logic [4:0]  seg_x_d [MAX_LEN];
    logic [4:0]  seg_y_q [MAX_LEN];
    logic [4:0]  seg_y_d [MAX_LEN];
    logic [4:0]  len_q, len_d;
    dir_t        dir_q, dir_d, pend_q, pend_d;
    logic [31:0] cnt_q, cnt_d;
    logic        step_q, step_d, ate_q, ate_d;
    logic        hit_wall_q, hit_wall_d, hit_self_q, hit_self_d;

    logic [31:0] period;
    dir_t        req_dir, pend_eff;
    logic [4:0]  nx, ny;
    logic        wall, food_hit, grow, self_hit;

    // Evaluate the candidate move: period, filtered direction, next head, collisions
    always_comb begin
        period = PER_SLOW;
        if (SW[2])      period = PER_FAST;
        else if (SW[1]) period = PER_MED;

        req_dir = DIR_RIGHT;
        if (BTN[0])      req_dir = DIR_UP;
        else if (BTN[1]) req_dir = DIR_DOWN;
        else if (BTN[2]) req_dir = DIR_LEFT;

        // A request arriving on the tick cycle itself steers that tick's move
        pend_eff = pend_q;
        if ((|BTN) && (req_dir != opposite(dir_q))) pend_eff = req_dir;

        nx   = seg_x_q[0];
        ny   = seg_y_q[0];
        wall = 1'b0;
        case (pend_eff)
            DIR_UP:    if (ny == '0)    wall = 1'b1; else ny = ny - 5'd1;
            DIR_DOWN:  if (ny == Y_MAX) wall = 1'b1; else ny = ny + 5'd1;
            DIR_LEFT:  if (nx == '0)    wall = 1'b1; else nx = nx - 5'd1;
            default:   if (nx == X_MAX) wall = 1'b1; else nx = nx + 5'd1;
        endcase

        food_hit = (nx == food_x) && (ny == food_y);
        grow     = food_hit && (len_q < LEN_MAX);

        // The tail cell only blocks when the snake grows and therefore keeps it
        self_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (((i + 2 <= 32'(len_q)) || (grow && (i + 1 == 32'(len_q)))) &&
                (seg_x_q[i] == nx) && (seg_y_q[i] == ny))
                self_hit = 1'b1;
        end
    end

    // Next-state selection driven by the game FSM state
    always_comb begin
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        step_d     = 1'b0;
        ate_d      = 1'b0;
        hit_wall_d = hit_wall_q;
        hit_self_d = hit_self_q;

        case (game_state_t'(game_state))
            GS_START: begin
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    seg_x_d[i] = init_x(i);
                    seg_y_d[i] = init_y(i);
                end
                len_d      = 5'd3;
                dir_d      = DIR_RIGHT;
                pend_d     = DIR_RIGHT;
                cnt_d      = '0;
                hit_wall_d = 1'b0;
                hit_self_d = 1'b0;
            end
            GS_PLAYING: begin
                pend_d = pend_eff;
                // >= so that a period lowered mid-count cannot run the counter past its compare
                if (cnt_q >= period - 32'd1) begin
                    cnt_d = '0;
                    dir_d = pend_eff;
                    if (wall) begin
                        hit_wall_d = 1'b1;
                    end else if (self_hit) begin
                        hit_self_d = 1'b1;
                    end else begin
                        for (int unsigned i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nx;
                        seg_y_d[0] = ny;
                        step_d     = 1'b1;
                        ate_d      = food_hit;
                        if (grow) len_d = len_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    // State register with asynchronous reset to the initial snake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
            len_q      <= 5'd3;
            dir_q      <= DIR_RIGHT;
            pend_q     <= DIR_RIGHT;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            ate_q      <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_self_q <= 1'b0;
        end else begin
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            ate_q      <= ate_d;
            hit_wall_q <= hit_wall_d;
            hit_self_q <= hit_self_d;
        end
    end

    // Output drive and combinational segment read port
    always_comb begin
        seg_x     = seg_x_q[qry_idx];
        seg_y     = seg_y_q[qry_idx];
        seg_valid = ({1'b0, qry_idx} < len_q);
        head_x    = seg_x_q[0];
        head_y    = seg_y_q[0];
        length    = len_q;
        step      = step_q;
        ate_food  = ate_q;
        hit_wall  = hit_wall_q;
        hit_self  = hit_self_q;
    end

endmodule

// File: tb/tb_snake_move.sv
// Self-checking bench for snake_move: directed scenarios plus randomized play
// compared against a queue-based model of the snake.
module tb_snake_move;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] game_state;
    logic [3:0] BTN;
    logic [2:0] SW;
    logic [4:0] food_x, food_y;
    logic [3:0] qry_idx;
    logic [4:0] seg_x, seg_y, head_x, head_y, length;
    logic       seg_valid, step, ate_food, hit_wall, hit_self;

    always #5 clk = ~clk;

    snake_move #(.P_SLOW(4), .P_MED(3), .P_FAST(2)) dut (
        .clk(clk), .reset(reset), .game_state(game_state), .BTN(BTN), .SW(SW),
        .food_x(food_x), .food_y(food_y), .qry_idx(qry_idx),
        .seg_x(seg_x), .seg_y(seg_y), .seg_valid(seg_valid),
        .head_x(head_x), .head_y(head_y), .length(length),
        .step(step), .ate_food(ate_food), .hit_wall(hit_wall), .hit_self(hit_self)
    );

    int errors = 0;
    int checks = 0;

    // Model: queue of cells, index 0 is the head; directions 0 up,1 down,2 left,3 right
    int mx[$], my[$];
    int m_cnt, m_dir, m_pend;
    bit m_step, m_ate, m_hw, m_hs;

    function automatic void model_init();
        mx = '{16, 15, 14};
        my = '{12, 12, 12};
        m_cnt = 0; m_dir = 3; m_pend = 3;
        m_step = 0; m_ate = 0; m_hw = 0; m_hs = 0;
    endfunction

    function automatic void model_step();
        int d, p, nx, ny, len;
        bit grow, hit, fm;
        m_step = 0; m_ate = 0;
        if (game_state == 2'b00) begin
            model_init();
        end else if (game_state == 2'b11) begin
            if (BTN != 0) begin
                d = BTN[0] ? 0 : BTN[1] ? 1 : BTN[2] ? 2 : 3;
                if (d != (m_dir ^ 1)) m_pend = d;
            end
            p = SW[2] ? 2 : SW[1] ? 3 : 4;
            if (m_cnt == p - 1) begin
                m_cnt = 0;
                m_dir = m_pend;
                nx = mx[0] + ((m_dir == 3) ? 1 : (m_dir == 2) ? -1 : 0);
                ny = my[0] + ((m_dir == 1) ? 1 : (m_dir == 0) ? -1 : 0);
                if (nx < 0 || nx > 31 || ny < 0 || ny > 23) begin
                    m_hw = 1;
                end else begin
                    len  = mx.size();
                    fm   = (nx == int'(food_x)) && (ny == int'(food_y));
                    grow = fm && (len < 16);
                    hit  = 0;
                    for (int i = 1; i < len; i++)
                        if ((i <= len - 2 || grow) && mx[i] == nx && my[i] == ny) hit = 1;
                    if (hit) begin
                        m_hs = 1;
                    end else begin
                        mx.push_front(nx); my.push_front(ny);
                        if (!grow) begin void'(mx.pop_back()); void'(my.pop_back()); end
                        m_step = 1;
                        m_ate  = fm;
                    end
                end
            end else begin
                m_cnt++;
            end
        end
    endfunction

    task automatic run_cycle();
        @(posedge clk);
        if (reset) model_init(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; game_state = 2'b00; BTN = '0; SW = 3'b001;
        food_x = '0; food_y = '0; qry_idx = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        model_init();
        checks++; if ({head_x, head_y} !== {5'd16, 5'd12}) begin errors++; $display("FAIL reset_head: got (%0d,%0d) want (16,12)", head_x, head_y); end
        checks++; if (length !== 5'd3) begin errors++; $display("FAIL reset_length: got %0d want 3", length); end
        checks++; if ({step, ate_food, hit_wall, hit_self} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {step, ate_food, hit_wall, hit_self}); end
        checks++; if ({seg_valid, seg_x, seg_y} !== {1'b1, 5'd14, 5'd12}) begin errors++; $display("FAIL reset_seg2: got v=%0d (%0d,%0d) want v=1 (14,12)", seg_valid, seg_x, seg_y); end
        qry_idx = 4'd3; #1;
        checks++; if (seg_valid !== 1'b0) begin errors++; $display("FAIL reset_seg3_valid: got %0d want 0", seg_valid); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        game_state = 2'b00; SW = 3'b001;
        repeat (2) run_cycle();
        game_state = 2'b11;
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            checks++; if (step !== m_step) begin errors++; $display("FAIL basic_step c=%0d: got %0d want %0d", c, step, m_step); end
            if (c == 3) begin checks++; if ({head_x, head_y} !== {5'd17, 5'd12}) begin errors++; $display("FAIL basic_head1: got (%0d,%0d) want (17,12)", head_x, head_y); end end
            if (c == 7) begin checks++; if ({head_x, head_y} !== {5'd18, 5'd12}) begin errors++; $display("FAIL basic_head2: got (%0d,%0d) want (18,12)", head_x, head_y); end end
        end
        checks++; if (length !== 5'd3) begin errors++; $display("FAIL basic_length: got %0d want 3", length); end
    endtask

    task automatic test_direction();
        bit seen;
        BTN = 4'b0100; run_cycle(); BTN = '0;
        seen = 0;
        for (int c = 0; c < 16 && !seen; c++) begin run_cycle(); seen = (step === 1'b1); end
        checks++; if (!seen) begin errors++; $display("FAIL dir_left_timeout: step got 0 want 1"); end
        checks++; if ({head_x, head_y} !== {5'd20, 5'd12}) begin errors++; $display("FAIL dir_left_ignored: got (%0d,%0d) want (20,12)", head_x, head_y); end
        BTN = 4'b0001; run_cycle(); BTN = 4'b1000; run_cycle(); BTN = '0;
        seen = 0;
        for (int c = 0; c < 16 && !seen; c++) begin run_cycle(); seen = (step === 1'b1); end
        checks++; if (!seen) begin errors++; $display("FAIL dir_last_timeout: step got 0 want 1"); end
        checks++; if ({head_x, head_y} !== {5'd21, 5'd12}) begin errors++; $display("FAIL dir_last_wins: got (%0d,%0d) want (21,12)", head_x, head_y); end
    endtask

    task automatic test_food();
        bit seen;
        game_state = 2'b00; food_x = 5'd17; food_y = 5'd12; SW = 3'b001;
        repeat (2) run_cycle();
        game_state = 2'b11;
        seen = 0;
        for (int c = 0; c < 16 && !seen; c++) begin run_cycle(); seen = (step === 1'b1); end
        checks++; if (!seen) begin errors++; $display("FAIL food_timeout: step got 0 want 1"); end
        checks++; if (ate_food !== 1'b1) begin errors++; $display("FAIL food_ate: got %0d want 1", ate_food); end
        checks++; if (length !== 5'd4) begin errors++; $display("FAIL food_length: got %0d want 4", length); end
        qry_idx = 4'd3; #1;
        checks++; if ({seg_valid, seg_x, seg_y} !== {1'b1, 5'd14, 5'd12}) begin errors++; $display("FAIL food_seg3: got v=%0d (%0d,%0d) want v=1 (14,12)", seg_valid, seg_x, seg_y); end
        run_cycle();
        checks++; if (ate_food !== 1'b0) begin errors++; $display("FAIL food_pulse_width: got %0d want 0", ate_food); end
    endtask

    task automatic test_wall();
        bit seen;
        game_state = 2'b00; food_x = '0; food_y = '0; SW = 3'b100;
        repeat (2) run_cycle();
        game_state = 2'b11;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            run_cycle();
            checks++; if ({step, head_x, head_y} !== {m_step, 5'(mx[0]), 5'(my[0])}) begin errors++; $display("FAIL wall_track c=%0d: got s=%0d (%0d,%0d) want s=%0d (%0d,%0d)", c, step, head_x, head_y, m_step, mx[0], my[0]); end
            seen = (hit_wall === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL wall_timeout: hit_wall got 0 want 1"); end
        checks++; if ({hit_self, step} !== 2'b00) begin errors++; $display("FAIL wall_only: got self=%0d step=%0d want 0 0", hit_self, step); end
        checks++; if ({head_x, head_y} !== {5'd31, 5'd12}) begin errors++; $display("FAIL wall_head: got (%0d,%0d) want (31,12)", head_x, head_y); end
        game_state = 2'b10;
        repeat (3) run_cycle();
        checks++; if ({hit_wall, head_x} !== {1'b1, 5'd31}) begin errors++; $display("FAIL wall_over_hold: got hw=%0d x=%0d want hw=1 x=31", hit_wall, head_x); end
        game_state = 2'b00;
        run_cycle();
        checks++; if ({hit_wall, hit_self, head_x, head_y, length} !== {2'b00, 5'd16, 5'd12, 5'd3}) begin errors++; $display("FAIL wall_restart: got hw=%0d hs=%0d (%0d,%0d) len=%0d want 0 0 (16,12) 3", hit_wall, hit_self, head_x, head_y, length); end
    endtask

    task automatic test_self();
        bit seen;
        int dirs[3] = '{0, 2, 1};
        int fx[2] = '{17, 18};
        for (int pass = 0; pass < 2; pass++) begin
            game_state = 2'b00; SW = 3'b001;
            repeat (2) run_cycle();
            game_state = 2'b11;
            for (int f = 0; f < 2 - pass; f++) begin
                food_x = 5'(fx[f]); food_y = 5'd12;
                seen = 0;
                for (int c = 0; c < 16 && !seen; c++) begin run_cycle(); seen = (step === 1'b1); end
                checks++; if (!seen || ate_food !== 1'b1) begin errors++; $display("FAIL self_grow p=%0d f=%0d: got step=%0d ate=%0d want 1 1", pass, f, step, ate_food); end
            end
            food_x = '0; food_y = '0;
            for (int k = 0; k < 3; k++) begin
                BTN = 4'(1 << dirs[k]); run_cycle(); BTN = '0;
                seen = 0;
                for (int c = 0; c < 16 && !seen; c++) begin run_cycle(); seen = (step === 1'b1) || (hit_self === 1'b1); end
                checks++; if (!seen) begin errors++; $display("FAIL self_turn_timeout p=%0d k=%0d: no step or hit", pass, k); end
            end
            if (pass == 0) begin
                checks++; if ({hit_self, hit_wall, step, length} !== {3'b100, 5'd5}) begin errors++; $display("FAIL self_uturn: got hs=%0d hw=%0d step=%0d len=%0d want 1 0 0 5", hit_self, hit_wall, step, length); end
                checks++; if ({head_x, head_y} !== {5'd17, 5'd11}) begin errors++; $display("FAIL self_uturn_head: got (%0d,%0d) want (17,11)", head_x, head_y); end
            end else begin
                checks++; if ({hit_self, step, length} !== {2'b01, 5'd4}) begin errors++; $display("FAIL self_tail_legal: got hs=%0d step=%0d len=%0d want 0 1 4", hit_self, step, length); end
                checks++; if ({head_x, head_y} !== {5'd16, 5'd12}) begin errors++; $display("FAIL self_tail_head: got (%0d,%0d) want (16,12)", head_x, head_y); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int first;
        game_state = 2'b00; SW = 3'b001; BTN = '0;
        repeat (2) run_cycle();
        game_state = 2'b11;
        seen = 0;
        for (int c = 0; c < 16 && !seen; c++) begin run_cycle(); seen = (step === 1'b1); end
        run_cycle();
        #2 reset = 1'b1;
        #1;
        checks++; if ({head_x, head_y, length, step, hit_wall, hit_self} !== {5'd16, 5'd12, 5'd3, 3'b000}) begin errors++; $display("FAIL rstmid_async: got (%0d,%0d) len=%0d s=%0d hw=%0d hs=%0d want (16,12) 3 0 0 0", head_x, head_y, length, step, hit_wall, hit_self); end
        run_cycle();
        reset = 1'b0;
        first = -1;
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            checks++; if ({step, head_x} !== {m_step, 5'(mx[0])}) begin errors++; $display("FAIL rstmid_track c=%0d: got s=%0d x=%0d want s=%0d x=%0d", c, step, head_x, m_step, mx[0]); end
            if (step === 1'b1 && first < 0) first = c;
        end
        checks++; if (first != 3) begin errors++; $display("FAIL rstmid_first_tick: got cycle %0d want 3", first); end
    endtask

    task automatic test_random();
        int sz;
        game_state = 2'b00; BTN = '0; SW = 3'b001;
        run_cycle();
        for (int n = 0; n < 1500; n++) begin
            if (m_hw || m_hs)                    game_state = 2'b00;
            else if ($urandom_range(0, 19) == 0) game_state = 2'($urandom_range(1, 2));
            else                                 game_state = 2'b11;
            BTN = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if (m_cnt == 0 && $urandom_range(0, 7) == 0) SW = 3'($urandom);
            if (n % 12 == 0) begin food_x = 5'($urandom_range(8, 24)); food_y = 5'($urandom_range(4, 20)); end
            qry_idx = 4'($urandom);
            run_cycle();
            sz = mx.size();
            checks++; if ({head_x, head_y} !== {5'(mx[0]), 5'(my[0])}) begin errors++; $display("FAIL rnd_head n=%0d: got (%0d,%0d) want (%0d,%0d)", n, head_x, head_y, mx[0], my[0]); end
            checks++; if (length !== 5'(sz)) begin errors++; $display("FAIL rnd_length n=%0d: got %0d want %0d", n, length, sz); end
            checks++; if ({step, ate_food, hit_wall, hit_self} !== {m_step, m_ate, m_hw, m_hs}) begin errors++; $display("FAIL rnd_flags n=%0d: got %b want %b", n, {step, ate_food, hit_wall, hit_self}, {m_step, m_ate, m_hw, m_hs}); end
            checks++; if (seg_valid !== (int'(qry_idx) < sz)) begin errors++; $display("FAIL rnd_valid n=%0d: got %0d want %0d", n, seg_valid, int'(qry_idx) < sz); end
            if (int'(qry_idx) < sz) begin
                checks++; if ({seg_x, seg_y} !== {5'(mx[qry_idx]), 5'(my[qry_idx])}) begin errors++; $display("FAIL rnd_seg n=%0d i=%0d: got (%0d,%0d) want (%0d,%0d)", n, qry_idx, seg_x, seg_y, mx[qry_idx], my[qry_idx]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_direction();
        test_food();
        test_wall();
        test_self();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_move.md
SNAKE_MOVE -- requirements
Module: snake_move

Interface
REQ-001 Parameter GRID_W, default 32, playfield width in cells; x range 0..GRID_W-1.
REQ-002 Parameter GRID_H, default 24, playfield height in cells; y range 0..GRID_H-1.
REQ-003 Parameter MAX_LEN, default 16, snake segment capacity.
REQ-004 Parameters P_SLOW / P_MED / P_FAST, defaults 50_000_000 / 25_000_000 / 12_500_000, step period in clk cycles.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 game_state  in  2  00 START, 01 PAUSE, 10 OVER, 11 PLAYING (from game FSM).
REQ-008 BTN  in  4  direction request: [0] up, [1] down, [2] left, [3] right; level, pre-debounced.
REQ-009 SW  in  3  difficulty select.
REQ-010 food_x / food_y  in  5 / 5  food cell.
REQ-011 qry_idx  in  4  segment index to read.
REQ-012 seg_x / seg_y / seg_valid  out  5 / 5 / 1  combinational read of segment qry_idx; seg_valid=1 iff qry_idx<length.
REQ-013 head_x / head_y  out  5 / 5  segment 0.
REQ-014 length  out  5  current segment count.
REQ-015 step  out  1  one-cycle pulse on each committed move.
REQ-016 ate_food  out  1  one-cycle pulse, coincident with step, when new head equals food.
REQ-017 hit_wall / hit_self  out  1 / 1  sticky collision flags to game FSM.

Function
REQ-018 Init state: seg0=(16,12), seg1=(15,12), seg2=(14,12), length=3, direction=right, pending direction=right, tick counter=0, step/ate_food/hit_wall/hit_self=0.
REQ-019 game_state=START: load init state every cycle.
REQ-020 game_state=PAUSE or OVER: hold all state; step and ate_food 0; counter frozen.
REQ-021 game_state=PLAYING: counter increments each cycle; at counter==P-1 a step tick occurs and counter wraps to 0.
REQ-022 P selection, priority SW[2]>SW[1]>SW[0]: SW[2]->P_FAST, SW[1]->P_MED, SW[0] or none->P_SLOW; P sampled at every tick, changes mid-count take effect at compare.
REQ-023 Direction request accepted any PLAYING cycle; multiple buttons resolved BTN[0]>BTN[1]>BTN[2]>BTN[3]; latest accepted request overwrites pending.
REQ-024 Request opposite to committed direction (direction of last move) is ignored; pending copied to committed at each tick.
REQ-025 At tick, next head = head +/-1 in committed direction (up = y-1, down = y+1, left = x-1, right = x+1).
REQ-026 Wall: x==0 moving left, x==GRID_W-1 moving right, y==0 moving up, y==GRID_H-1 moving down -> hit_wall=1, no move, no step pulse.
REQ-027 Growth: grow = (next head == food) and length<MAX_LEN.
REQ-028 Self: next head equals seg[i] for 1<=i<=length-2, or i=length-1 when grow=1 -> hit_self=1, no move, no step pulse; moving into vacating tail cell is legal.
REQ-029 Wall check has priority; never both flags set on one tick.
REQ-030 Legal move: seg[i]<=seg[i-1] for i>=1, seg0<=next head, step=1; if grow, length+1.
REQ-031 Next head == food at length==MAX_LEN: ate_food=1, length holds at MAX_LEN, tail drops.
REQ-032 Segments at index >=length hold don't-care data; seg_valid gates them.
REQ-033 hit flags stay set until START or reset.

Reset
REQ-034 reset asserted, including mid-step: all state takes init values of REQ-018 immediately and holds until release.
REQ-035 First tick after reset release occurs P cycles after game_state first equals PLAYING.

Verification (bench uses P_*=4/3/2)
REQ-036 START, then PLAYING with SW=001, no BTN -> step every 4 cycles; head (17,12),(18,12); length 3.
REQ-037 Heading right, press BTN[2] (left) -> ignored, head x+1; then BTN[0] then BTN[3] in same step period -> moves right (last request wins).
REQ-038 food=(17,12), first tick -> ate_food and step pulse, length 4, seg3=(14,12).
REQ-039 Drive head to x=31 heading right -> next tick hit_wall=1, head stays (31,y), step=0; game_state OVER then START -> flags 0, init positions.
REQ-040 Length 5 in U-turn (up, left, down sequence) -> head into body seg gives hit_self=1; length-4 square loop into tail cell gives legal move.
REQ-041 reset pulse during PLAYING between ticks -> outputs init values within same cycle, counter 0.
